deslocamento_esquerda: RTL and testbench
========================================

# deslocamento_esquerda

Registered logical left shifter for the datapath. It shifts a WIDTH-bit word left by a fixed number of bit positions, filling vacated LSBs with zeros, and presents the result one clock later. Its main use is scaling branch/jump word offsets to byte offsets (shift by 2) ahead of the PC adder. An optional overflow flag reports lost significant bits.

## Interface
- WIDTH, 32: data width in bits; legal range 2 to 64.
- SHIFT, 2: fixed left-shift amount; legal range 0 to WIDTH-1; any other value must stop elaboration with an error.

- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- sinal_original  input  WIDTH  word to shift.
- sinal_deslocado  output  WIDTH  registered shifted word.
- overflow  output  1  registered flag: a 1 was shifted out (present only with the macro).
- Declaration order: clock, sinal_original, sinal_deslocado, reset_n, overflow. Existing 3-port positional instantiations keep their first three positions.
- Clocking and reset: one clock; reset is asynchronous and active-low.

## Operation
- Logical shift only; no arithmetic or rotate mode.
- Next value: sinal_deslocado = {sinal_original[WIDTH-1-SHIFT:0], SHIFT zeros}.
- SHIFT = 0: the output is a registered copy of the input.
- The top SHIFT input bits are discarded.
- overflow next value = OR of sinal_original[WIDTH-1:WIDTH-SHIFT]. It is 0 whenever SHIFT = 0.
- No enable and no handshake: a new result is captured on every rising clock edge.
- X or Z on input bits propagates only to the affected output bits. Zero-filled bits are always 0.

## Timing
- Latency is 1 cycle. The input is sampled on the rising edge of clock, and the output is updated right after that edge and held until the next edge.
- Input changes between edges have no effect on the outputs until the next rising edge.
- Asserting reset_n low forces sinal_deslocado = 0 and overflow = 0 immediately, with no clock needed. It overrides any edge during the same timestep.
- While reset_n is low, the outputs stay 0 regardless of clock or input.
- On the first rising edge with reset_n high, the current input is captured normally.
- Reset asserted mid-stream: the in-flight result is discarded and there is no recovery of the prior value.
- Before the first reset or the first edge, the outputs are undefined. Benches must apply reset first.

## Configuration
- Macro DESLOCAMENTO_ESQUERDA_OVERFLOW_EN.
- Defined: the overflow port and its register exist, with behaviour as above.
- Undefined: no overflow port, no overflow logic, and a strictly 4-port interface. sinal_deslocado behaviour is identical in both builds.

## Test plan
- Reset: hold reset_n = 0 with input 0xFFFFFFFF and clock toggling -> sinal_deslocado = 0 and overflow = 0 throughout.
- Basic shift (SHIFT = 2): 0x00000004 applied, then a rising edge -> 0x00000010. Next 0x00000008 -> 0x00000020 after the following edge. Output unchanged between edges.
- Discarded MSBs: 0xC0000001 -> 0x00000004 with overflow = 1. Then 0x3FFFFFFF -> 0xFFFFFFFC with overflow = 0.
- Asynchronous reset mid-stream: output at 0x00000020, pull reset_n low between edges -> 0 within the same timestep. Release, and the next edge with 0x00000001 -> 0x00000004.
- Parameter sweep: WIDTH = 8, SHIFT = 0 with 0xA5 -> 0xA5. WIDTH = 8, SHIFT = 7 with 0x03 -> 0x80 and overflow = 1.
- Build without the macro: the 4-port compile succeeds, and the basic-shift results are identical.

Source files
------------

// File: rtl/deslocamento_esquerda.sv
// deslocamento_esquerda: registered logical left shift by a fixed SHIFT, zero-filled LSBs.
// Define DESLOCAMENTO_ESQUERDA_OVERFLOW_EN to add the registered overflow port.
module deslocamento_esquerda #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 2
) (
    input  logic             clock,
    input  logic [WIDTH-1:0] sinal_original,
    output logic [WIDTH-1:0] sinal_deslocado,
    input  logic             reset_n
`ifdef DESLOCAMENTO_ESQUERDA_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);
    logic [WIDTH-1:0] deslocado_d, deslocado_q;

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("deslocamento_esquerda: WIDTH must be 2..64");
    end
    if (SHIFT < 0 || SHIFT > WIDTH - 1) begin : g_bad_shift
        $error("deslocamento_esquerda: SHIFT must be 0..WIDTH-1");
    end

    assign deslocado_d = sinal_original << SHIFT;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            deslocado_q <= '0;
        else
            deslocado_q <= deslocado_d;
    end

    assign sinal_deslocado = deslocado_q;

`ifdef DESLOCAMENTO_ESQUERDA_OVERFLOW_EN
    logic overflow_d, overflow_q;

    // A zero-width slice is illegal, so SHIFT = 0 gets a constant flag.
    if (SHIFT == 0) begin : g_ovf_none
        assign overflow_d = 1'b0;
    end else begin : g_ovf
        assign overflow_d = |sinal_original[WIDTH-1 -: SHIFT];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            overflow_q <= 1'b0;
        else
            overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`endif
endmodule

// File: tb/tb_deslocamento_esquerda.sv
// tb_deslocamento_esquerda: directed vectors for the default, 8/0 and 8/7 shifter builds.
module tb_deslocamento_esquerda;
    logic        clock;
    logic        reset_n;
    logic [31:0] din;
    logic [31:0] dout;
    logic [7:0]  din8a, dout8a, din8b, dout8b;
    int          total, bad;
`ifdef DESLOCAMENTO_ESQUERDA_OVERFLOW_EN
    logic ovf, ovf8a, ovf8b;
`endif

    deslocamento_esquerda dut (
        .clock(clock), .sinal_original(din), .sinal_deslocado(dout), .reset_n(reset_n)
`ifdef DESLOCAMENTO_ESQUERDA_OVERFLOW_EN
        , .overflow(ovf)
`endif
    );

    deslocamento_esquerda #(.WIDTH(8), .SHIFT(0)) dut8a (
        .clock(clock), .sinal_original(din8a), .sinal_deslocado(dout8a), .reset_n(reset_n)
`ifdef DESLOCAMENTO_ESQUERDA_OVERFLOW_EN
        , .overflow(ovf8a)
`endif
    );

    deslocamento_esquerda #(.WIDTH(8), .SHIFT(7)) dut8b (
        .clock(clock), .sinal_original(din8b), .sinal_deslocado(dout8b), .reset_n(reset_n)
`ifdef DESLOCAMENTO_ESQUERDA_OVERFLOW_EN
        , .overflow(ovf8b)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        din = 32'hFFFF_FFFF;
        din8a = 8'hFF;
        din8b = 8'hFF;
        #1;
        check("rst_async", dout, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold", dout, 0);
`ifdef DESLOCAMENTO_ESQUERDA_OVERFLOW_EN
            check("rst_ovf", ovf, 0);
`endif
        end
        check("rst_w8s0", dout8a, 0);
        check("rst_w8s7", dout8b, 0);

        @(negedge clock);
        reset_n = 1'b1;
        din = 32'h0000_0004;
        tick();
        check("shift_4", dout, 32'h0000_0010);
        din = 32'h0000_0008;
        #2;
        check("hold_between", dout, 32'h0000_0010);
        tick();
        check("shift_8", dout, 32'h0000_0020);

        din = 32'hC000_0001;
        tick();
        check("msb_drop", dout, 32'h0000_0004);
`ifdef DESLOCAMENTO_ESQUERDA_OVERFLOW_EN
        check("ovf_set", ovf, 1);
`endif
        din = 32'h3FFF_FFFF;
        tick();
        check("no_drop", dout, 32'hFFFF_FFFC);
`ifdef DESLOCAMENTO_ESQUERDA_OVERFLOW_EN
        check("ovf_clr", ovf, 0);
`endif

        din = 32'h0000_0008;
        tick();
        check("pre_rst", dout, 32'h0000_0020);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst", dout, 0);
        tick();
        check("rst_edge", dout, 0);
        @(negedge clock);
        reset_n = 1'b1;
        din = 32'h0000_0001;
        tick();
        check("post_rst", dout, 32'h0000_0004);

        din8a = 8'hA5;
        din8b = 8'h03;
        tick();
        check("w8s0", dout8a, 8'hA5);
        check("w8s7", dout8b, 8'h80);
`ifdef DESLOCAMENTO_ESQUERDA_OVERFLOW_EN
        check("w8s0_ovf", ovf8a, 0);
        check("w8s7_ovf", ovf8b, 1);
`endif
        din8a = 8'h5A;
        din8b = 8'h02;
        tick();
        check("w8s0_b", dout8a, 8'h5A);
        check("w8s7_b", dout8b, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
